// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped L1 data cache.
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int LINES      = 32;
    localparam int IDX_W      = $clog2(LINES);
    localparam int BLOCK_W    = 256;
    localparam int WORD_W     = 32;
    localparam int WORDS      = BLOCK_W / WORD_W;
    localparam int WORD_SEL_W = $clog2(WORDS);
    localparam int TAG_W      = 22;

    // Byte-address field boundaries: tag | index | word | byte
    localparam int TAG_LSB  = 10;
    localparam int IDX_LSB  = 5;
    localparam int WORD_LSB = 2;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    // Block-aligned byte address of a line, as presented to the memory side.
    function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag,
                                                      input logic [IDX_W-1:0] idx);
        return {tag, idx, {IDX_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Per-line storage: tag, valid, dirty and data. One synchronous write port,
// asynchronous read at the same index so hits resolve in the access cycle.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               we_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic               valid_i,
    input  logic               dirty_i,
    output logic [TAG_W-1:0]   tag_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               valid_o,
    output logic               dirty_o
);

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [BLOCK_W-1:0] data_mem [LINES];
    logic [LINES-1:0]   valid_vec;
    logic [LINES-1:0]   dirty_vec;

    // Tag and data are not reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_mem[idx_i]  <= tag_i;
            data_mem[idx_i] <= data_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            logic valid_q;
            logic valid_d;
            logic dirty_q;
            logic dirty_d;

            // Next valid/dirty for this line: only changes when this index is written.
            always_comb begin
                valid_d = valid_q;
                dirty_d = dirty_q;
                if (we_i && (idx_i == IDX_W'(gi))) begin
                    valid_d = valid_i;
                    dirty_d = dirty_i;
                end
            end

            // Status bits clear on reset so every line starts out as a miss.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    dirty_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                    dirty_q <= dirty_d;
                end
            end

            assign valid_vec[gi] = valid_q;
            assign dirty_vec[gi] = dirty_q;
        end
    endgenerate

    assign tag_o   = tag_mem[idx_i];
    assign data_o  = data_mem[idx_i];
    assign valid_o = valid_vec[idx_i];
    assign dirty_o = dirty_vec[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate L1 data cache controller.
// Hits complete combinationally; a miss stalls the pipeline while the FSM
// optionally writes back the victim and then refills the line.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_req_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    // Request address split
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WORD_SEL_W-1:0] req_word;
    logic                  unused_byte_sel;

    assign req_tag         = p1_addr_i[ADDR_W-1:TAG_LSB];
    assign req_idx         = p1_addr_i[TAG_LSB-1:IDX_LSB];
    assign req_word        = p1_addr_i[IDX_LSB-1:WORD_LSB];
    assign unused_byte_sel = ^p1_addr_i[WORD_LSB-1:0];

    // Line storage interface
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               line_valid;
    logic               line_dirty;
    logic               sram_we;
    logic [BLOCK_W-1:0] sram_data_in;
    logic               sram_dirty_in;

    dcache_sram u_sram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .idx_i   (req_idx),
        .we_i    (sram_we),
        .tag_i   (req_tag),
        .data_i  (sram_data_in),
        .valid_i (1'b1),
        .dirty_i (sram_dirty_in),
        .tag_o   (line_tag),
        .data_o  (line_data),
        .valid_o (line_valid),
        .dirty_o (line_dirty)
    );

    // FSM and registered memory-side outputs
    state_t             state_q;
    state_t             state_d;
    logic               mem_enable_q;
    logic               mem_enable_d;
    logic               mem_write_q;
    logic               mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [BLOCK_W-1:0] mem_data_q;
    logic [BLOCK_W-1:0] mem_data_d;

    // Hit detection and CPU-side responses
    logic hit;
    logic fill;
    logic wr_hit;

    assign hit        = p1_req_i & line_valid & (line_tag == req_tag);
    assign p1_stall_o = p1_req_i & ~hit;

    // A refill lands on the ack edge; a store hit (including the cycle right
    // after a refill) merges its word and marks the line dirty.
    assign fill          = (state_q == READMISS) & mem_ack_i;
    assign wr_hit        = p1_req_i & p1_write_i & hit;
    assign sram_we       = fill | wr_hit;
    assign sram_dirty_in = ~fill;

    // Word select for loads and word merge for stores
    logic [WORD_W-1:0]  line_words [WORDS];
    logic [BLOCK_W-1:0] merged_line;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            assign line_words[gi] = line_data[gi*WORD_W +: WORD_W];
            assign merged_line[gi*WORD_W +: WORD_W] =
                (req_word == WORD_SEL_W'(gi)) ? p1_data_i : line_data[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign p1_data_o    = line_words[req_word];
    assign sram_data_in = fill ? mem_data_i : merged_line;

    // Next-state and next memory-request computation.
    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        case (state_q)
            IDLE: begin
                if (p1_stall_o) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                mem_enable_d = 1'b1;
                if (line_valid && line_dirty) begin
                    state_d     = WRITEBACK;
                    mem_write_d = 1'b1;
                    mem_addr_d  = block_addr(line_tag, req_idx);
                    mem_data_d  = line_data;
                end else begin
                    state_d     = READMISS;
                    mem_write_d = 1'b0;
                    mem_addr_d  = block_addr(req_tag, req_idx);
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d     = READMISS;
                    mem_write_d = 1'b0;
                    mem_addr_d  = block_addr(req_tag, req_idx);
                end
            end
            READMISS: begin
                if (mem_ack_i) begin
                    state_d      = READMISSOK;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end
            READMISSOK: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    // State and memory-side output registers; reset abandons any request at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule
